// File: rtl/hsv_adjust_pipe.sv
// hsv_adjust_pipe: HSV-domain adjust stage (hue rotate, saturation/value gain
// with clamping) with a fixed 3-cycle latency and frame-start control shadowing.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   h_in/s_in/v_in           input pixel (hue, saturation, value)
//   valid_in/sop_in/eop_in   pixel valid and frame framing sideband
//   gain_s/gain_v            unsigned gains, GF fractional bits
//   hue_off                  signed hue offset, -H_MAX..+H_MAX
//   bypass                   pass H/S/V unchanged with the same latency
//   h_out/s_out/v_out        adjusted pixel
//   valid_out/sop_out/eop_out sideband delayed by 3 cycles
//   frame_err                1-cycle pulse on a framing error
//   frame_cnt                completed frame count (wrapping)
module hsv_adjust_pipe #(
    parameter int unsigned HW    = 9,
    parameter int unsigned H_MAX = 359,
    parameter int unsigned SW    = 11,
    parameter int unsigned VW    = 8,
    parameter int unsigned GW    = 9,
    parameter int unsigned GF    = 8,
    parameter int unsigned FCW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HW-1:0]        h_in,
    input  logic [SW-1:0]        s_in,
    input  logic [VW-1:0]        v_in,
    input  logic                 valid_in,
    input  logic                 sop_in,
    input  logic                 eop_in,
    input  logic [GW-1:0]        gain_s,
    input  logic [GW-1:0]        gain_v,
    input  logic signed [HW:0]   hue_off,
    input  logic                 bypass,
    output logic [HW-1:0]        h_out,
    output logic [SW-1:0]        s_out,
    output logic [VW-1:0]        v_out,
    output logic                 valid_out,
    output logic                 sop_out,
    output logic                 eop_out,
    output logic                 frame_err,
    output logic [FCW-1:0]       frame_cnt
);

    localparam int unsigned HSW = HW + 2;
    localparam int unsigned PSW = SW + GW;
    localparam int unsigned PVW = VW + GW;

    localparam logic [GW-1:0]         GAIN_ONE = GW'(1 << GF);
    localparam logic [HW-1:0]         H_MAX_U  = HW'(H_MAX);
    localparam logic signed [HSW-1:0] H_MAX_S  = HSW'(H_MAX);
    localparam logic signed [HSW-1:0] H_MOD_S  = HSW'(H_MAX + 1);
    localparam logic [PSW-1:0]        S_SAT    = PSW'({SW{1'b1}});
    localparam logic [PVW-1:0]        V_SAT    = PVW'({VW{1'b1}});

    typedef enum logic {IDLE, ACTIVE} state_e;

    // Shadowed controls; _d is also what the current pixel uses
    logic [GW-1:0]      sh_gs_q, sh_gs_d, sh_gv_q, sh_gv_d;
    logic signed [HW:0] sh_off_q, sh_off_d;
    logic               sh_byp_q, sh_byp_d;
    logic               sop_hit;

    // Stage 1
    logic [HW-1:0]      h1_q, h1_d;
    logic [SW-1:0]      s1_q;
    logic [VW-1:0]      v1_q;
    logic [GW-1:0]      gs1_q, gv1_q;
    logic signed [HW:0] off1_q;
    logic               byp1_q, vld1_q, sop1_q, eop1_q;

    // Stage 2
    logic signed [HSW-1:0] hsum2_q, hsum2_d;
    logic [PSW-1:0]        ps2_q, ps2_d;
    logic [PVW-1:0]        pv2_q, pv2_d;
    logic [HW-1:0]         h2_q;
    logic [SW-1:0]         s2_q;
    logic [VW-1:0]         v2_q;
    logic                  byp2_q, vld2_q, sop2_q, eop2_q;

    // Stage 3 (outputs)
    logic [HW-1:0]         h3_q, h3_d;
    logic [SW-1:0]         s3_q, s3_d;
    logic [VW-1:0]         v3_q, v3_d;
    logic                  vld3_q, sop3_q, eop3_q;
    logic signed [HSW-1:0] hwrap;
    logic [PSW-1:0]        ps_sh;
    logic [PVW-1:0]        pv_sh;

    // Framing tracker
    state_e          state_q;
    logic            err_q;
    logic [FCW-1:0]  cnt_q;

    // Controls captured at frame start also apply to the sop pixel itself
    always_comb begin
        sop_hit  = valid_in & sop_in;
        sh_gs_d  = sop_hit ? gain_s  : sh_gs_q;
        sh_gv_d  = sop_hit ? gain_v  : sh_gv_q;
        sh_off_d = sop_hit ? hue_off : sh_off_q;
        sh_byp_d = sop_hit ? bypass  : sh_byp_q;
        h1_d     = (h_in > H_MAX_U) ? H_MAX_U : h_in;
    end

    // Shadow control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_gs_q  <= GAIN_ONE;
            sh_gv_q  <= GAIN_ONE;
            sh_off_q <= '0;
            sh_byp_q <= 1'b0;
        end else begin
            sh_gs_q  <= sh_gs_d;
            sh_gv_q  <= sh_gv_d;
            sh_off_q <= sh_off_d;
            sh_byp_q <= sh_byp_d;
        end
    end

    // Stage 2 arithmetic: signed hue sum, full-width products
    always_comb begin
        hsum2_d = HSW'(h1_q) + HSW'(off1_q);
        ps2_d   = PSW'(s1_q) * PSW'(gs1_q);
        pv2_d   = PVW'(v1_q) * PVW'(gv1_q);
    end

    // Stage 3: single-step hue wrap (sum is within -H_MAX..2*H_MAX), truncating shift, clamp
    always_comb begin
        hwrap = hsum2_q;
        if (hsum2_q > H_MAX_S) begin
            hwrap = hsum2_q - H_MOD_S;
        end else if (hsum2_q[HSW-1]) begin
            hwrap = hsum2_q + H_MOD_S;
        end
        ps_sh = ps2_q >> GF;
        pv_sh = pv2_q >> GF;
        h3_d  = hwrap[HW-1:0];
        s3_d  = (ps_sh > S_SAT) ? {SW{1'b1}} : ps_sh[SW-1:0];
        v3_d  = (pv_sh > V_SAT) ? {VW{1'b1}} : pv_sh[VW-1:0];
        if (byp2_q) begin
            h3_d = h2_q;
            s3_d = s2_q;
            v3_d = v2_q;
        end
    end

    // Pipeline registers; data advances every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1_q <= '0; s1_q <= '0; v1_q <= '0;
            gs1_q <= '0; gv1_q <= '0; off1_q <= '0;
            byp1_q <= 1'b0; vld1_q <= 1'b0; sop1_q <= 1'b0; eop1_q <= 1'b0;
            hsum2_q <= '0; ps2_q <= '0; pv2_q <= '0;
            h2_q <= '0; s2_q <= '0; v2_q <= '0;
            byp2_q <= 1'b0; vld2_q <= 1'b0; sop2_q <= 1'b0; eop2_q <= 1'b0;
            h3_q <= '0; s3_q <= '0; v3_q <= '0;
            vld3_q <= 1'b0; sop3_q <= 1'b0; eop3_q <= 1'b0;
        end else begin
            h1_q <= h1_d; s1_q <= s_in; v1_q <= v_in;
            gs1_q <= sh_gs_d; gv1_q <= sh_gv_d; off1_q <= sh_off_d;
            byp1_q <= sh_byp_d; vld1_q <= valid_in; sop1_q <= sop_in; eop1_q <= eop_in;
            hsum2_q <= hsum2_d; ps2_q <= ps2_d; pv2_q <= pv2_d;
            h2_q <= h1_q; s2_q <= s1_q; v2_q <= v1_q;
            byp2_q <= byp1_q; vld2_q <= vld1_q; sop2_q <= sop1_q; eop2_q <= eop1_q;
            h3_q <= h3_d; s3_q <= s3_d; v3_q <= v3_d;
            vld3_q <= vld2_q; sop3_q <= sop2_q; eop3_q <= eop2_q;
        end
    end

    // Frame tracker: only valid cycles are considered; error is a 1-cycle pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (valid_in) begin
                case (state_q)
                    IDLE: begin
                        if (sop_in) begin
                            if (eop_in) begin
                                cnt_q <= cnt_q + FCW'(1);
                            end else begin
                                state_q <= ACTIVE;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (sop_in) begin
                            err_q <= 1'b1;
                            if (eop_in) begin
                                cnt_q   <= cnt_q + FCW'(1);
                                state_q <= IDLE;
                            end
                        end else if (eop_in) begin
                            cnt_q   <= cnt_q + FCW'(1);
                            state_q <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign h_out     = h3_q;
    assign s_out     = s3_q;
    assign v_out     = v3_q;
    assign valid_out = vld3_q;
    assign sop_out   = sop3_q;
    assign eop_out   = eop3_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_hsv_adjust_pipe.sv
// tb_hsv_adjust_pipe: directed bench for hsv_adjust_pipe at default parameters.
module tb_hsv_adjust_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic [8:0]         h_in;
    logic [10:0]        s_in;
    logic [7:0]         v_in;
    logic               valid_in, sop_in, eop_in;
    logic [8:0]         gain_s, gain_v;
    logic signed [9:0]  hue_off;
    logic               bypass;
    logic [8:0]         h_out;
    logic [10:0]        s_out;
    logic [7:0]         v_out;
    logic               valid_out, sop_out, eop_out, frame_err;
    logic [15:0]        frame_cnt;

    int checks = 0;
    int errors = 0;

    hsv_adjust_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .h_in      (h_in),
        .s_in      (s_in),
        .v_in      (v_in),
        .valid_in  (valid_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .gain_s    (gain_s),
        .gain_v    (gain_v),
        .hue_off   (hue_off),
        .bypass    (bypass),
        .h_out     (h_out),
        .s_out     (s_out),
        .v_out     (v_out),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge
    task automatic pix(input int h, input int s, input int v,
                       input bit vld, input bit sp, input bit ep);
        h_in     = 9'(h);
        s_in     = 11'(s);
        v_in     = 8'(v);
        valid_in = vld;
        sop_in   = sp;
        eop_in   = ep;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix(0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Single-pixel frame, then wait until its result is on the outputs
    task automatic frame1(input int h, input int s, input int v);
        pix(h, s, v, 1'b1, 1'b1, 1'b1);
        idle();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        h_in = '0; s_in = '0; v_in = '0;
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        gain_s = 9'd256; gain_v = 9'd256; hue_off = '0; bypass = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_h", 32'(h_out), 0);
        chk("rst_s", 32'(s_out), 0);
        chk("rst_v", 32'(v_out), 0);
        chk("rst_sop_eop", 32'({sop_out, eop_out}), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Identity: 16-pixel ramp frame
        for (int j = 0; j < 18; j++) begin
            if (j < 16) pix(j * 20, j * 100, j * 15, 1'b1, j == 0, j == 15);
            else idle();
            if (j == 0) chk("id_err", 32'(frame_err), 0);
            if (j == 15) chk("id_cnt", 32'(frame_cnt), 1);
            if (j >= 2) begin
                chk("id_h", 32'(h_out), 32'((j - 2) * 20));
                chk("id_s", 32'(s_out), 32'((j - 2) * 100));
                chk("id_v", 32'(v_out), 32'((j - 2) * 15));
                chk("id_valid", 32'(valid_out), 1);
                chk("id_sop", 32'(sop_out), 32'(j == 2));
                chk("id_eop", 32'(eop_out), 32'(j == 17));
            end
        end

        // Hue wrap
        hue_off = 10'sd100;
        frame1(300, 50, 60);
        chk("wrap_hi_h", 32'(h_out), 40);
        chk("wrap_hi_valid", 32'(valid_out), 1);
        chk("wrap_sop_eop", 32'({sop_out, eop_out}), 3);
        chk("wrap_cnt", 32'(frame_cnt), 2);
        hue_off = -10'sd50;
        frame1(20, 50, 60);
        chk("wrap_lo_h", 32'(h_out), 330);
        hue_off = 10'sd0;
        frame1(400, 50, 60);
        chk("clamp_h", 32'(h_out), 359);
        hue_off = 10'sd359;
        frame1(359, 50, 60);
        chk("wrap_max_h", 32'(h_out), 358);
        hue_off = -10'sd359;
        frame1(0, 50, 60);
        chk("wrap_min_h", 32'(h_out), 1);
        chk("wrap_cnt2", 32'(frame_cnt), 6);

        // Gain and clamp
        hue_off = 10'sd0;
        gain_s = 9'd128; gain_v = 9'd512 - 9'd1;
        gain_v = 9'd511;
        frame1(10, 1001, 200);
        chk("gain_s_half", 32'(s_out), 500);
        chk("gain_v_clamp", 32'(v_out), 255);
        chk("gain_h", 32'(h_out), 10);
        gain_s = 9'd511; gain_v = 9'd0;
        frame1(10, 2047, 200);
        chk("gain_s_clamp", 32'(s_out), 2047);
        chk("gain_v_zero", 32'(v_out), 0);
        chk("gain_cnt", 32'(frame_cnt), 8);

        // Shadowing: mid-frame gain change ignored until next sop
        gain_s = 9'd256; gain_v = 9'd256;
        pix(10, 20, 100, 1'b1, 1'b1, 1'b0);
        pix(10, 20, 101, 1'b1, 1'b0, 1'b0);
        gain_v = 9'd256 + 9'd255;
        pix(10, 20, 102, 1'b1, 1'b0, 1'b0);
        chk("shd_a0", 32'(v_out), 100);
        pix(10, 20, 103, 1'b1, 1'b0, 1'b1);
        chk("shd_a1", 32'(v_out), 101);
        chk("shd_cnt_a", 32'(frame_cnt), 9);
        pix(10, 20, 100, 1'b1, 1'b1, 1'b0);
        chk("shd_a2", 32'(v_out), 102);
        pix(10, 20, 101, 1'b1, 1'b0, 1'b1);
        chk("shd_a3", 32'(v_out), 103);
        chk("shd_cnt_b", 32'(frame_cnt), 10);
        idle();
        chk("shd_b0", 32'(v_out), 199);
        idle();
        chk("shd_b1", 32'(v_out), 201);
        gain_v = 9'd256;

        // Framing
        pix(1, 1, 1, 1'b1, 1'b1, 1'b0);
        chk("frm_sop_err", 32'(frame_err), 0);
        pix(1, 1, 1, 1'b1, 1'b1, 1'b0);
        chk("frm_dsop_err", 32'(frame_err), 1);
        pix(1, 1, 1, 1'b1, 1'b0, 1'b0);
        chk("frm_pulse", 32'(frame_err), 0);
        pix(1, 1, 1, 1'b1, 1'b0, 1'b1);
        chk("frm_eop_err", 32'(frame_err), 0);
        chk("frm_cnt1", 32'(frame_cnt), 11);
        pix(1, 1, 1, 1'b1, 1'b0, 1'b0);
        chk("frm_nosop_err", 32'(frame_err), 1);
        idle();
        chk("frm_idle_err", 32'(frame_err), 0);
        pix(1, 1, 1, 1'b1, 1'b1, 1'b0);
        pix(1, 1, 1, 1'b1, 1'b1, 1'b1);
        chk("frm_act_se_err", 32'(frame_err), 1);
        chk("frm_cnt2", 32'(frame_cnt), 12);
        pix(1, 1, 1, 1'b1, 1'b1, 1'b1);
        chk("frm_idle_se_err", 32'(frame_err), 0);
        chk("frm_cnt3", 32'(frame_cnt), 13);
        idle();
        idle();

        // Asynchronous reset mid-frame
        pix(100, 100, 100, 1'b1, 1'b1, 1'b0);
        pix(101, 101, 101, 1'b1, 1'b0, 1'b0);
        pix(102, 102, 102, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(valid_out), 1);
        chk("pre_rst_h", 32'(h_out), 100);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_h", 32'(h_out), 0);
        chk("arst_v", 32'(v_out), 0);
        chk("arst_cnt", 32'(frame_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pix(5, 5, 5, 1'b1, 1'b0, 1'b0);
        chk("arst_nosop_err", 32'(frame_err), 1);
        idle();

        // Bypass frame: exact passthrough, bypass latched at sop
        bypass = 1'b1; gain_s = 9'd0; gain_v = 9'd511; hue_off = 10'sd100;
        pix(359, 2047, 255, 1'b1, 1'b1, 1'b0);
        bypass = 1'b0;
        pix(123, 5, 7, 1'b1, 1'b0, 1'b1);
        chk("byp_cnt", 32'(frame_cnt), 1);
        idle();
        chk("byp_h0", 32'(h_out), 359);
        chk("byp_s0", 32'(s_out), 2047);
        chk("byp_v0", 32'(v_out), 255);
        idle();
        chk("byp_h1", 32'(h_out), 123);
        chk("byp_s1", 32'(s_out), 5);
        chk("byp_v1", 32'(v_out), 7);
        chk("byp_eop", 32'(eop_out), 1);
        idle();
        chk("byp_end_valid", 32'(valid_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
